// File: rtl/reg_file_32x32_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_32x32_pkg
// Shared constants and types for the 32 x 32-bit register file.
//   REG_COUNT  : number of architectural registers
//   REG_WIDTH  : bits per register
//   REG_ADDR_W : register-number width
//   ZERO_REG   : register number that may be hardwired to zero
// -----------------------------------------------------------------------------
package reg_file_32x32_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_WIDTH  = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0]  reg_data_t;
    typedef logic [REG_COUNT-1:0]  reg_sel_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    // True when a write to / read from 'addr' must behave as the constant-zero
    // register rather than real storage.
    function automatic logic is_zero_reg(input logic zero_en, input reg_addr_t addr);
        return zero_en && (addr == ZERO_REG);
    endfunction

endpackage : reg_file_32x32_pkg

// File: rtl/reg_file_32x32_reg32.sv
// -----------------------------------------------------------------------------
// reg32
// One 32-bit storage register with asynchronous active-low clear and a
// synchronous load enable.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear (q -> 0 immediately)
//   en    : load enable, sampled on the rising edge
//   d     : data to load
//   q     : stored value
// -----------------------------------------------------------------------------
module reg32
    import reg_file_32x32_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [REG_WIDTH-1:0] d,
    output logic [REG_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : reg32

// File: rtl/reg_file_32x32.sv
// -----------------------------------------------------------------------------
// reg_file_32x32
// 32-entry, 32-bit register file: one synchronous write port, two
// combinational read ports, optional write-first bypass and optional
// hardwired-zero R0.
//
// Parameters
//   ZERO_REG0 : 1 -> R0 reads 0 and writes to it are dropped
//   BYPASS    : 1 -> a read of the register being written this cycle returns
//               WriteData before the edge
// Ports
//   Clk       : clock, all state changes on the rising edge
//   Reset_n   : asynchronous active-low reset, clears every register
//   RegWrite  : write enable
//   WriteReg  : destination register number
//   WriteData : data to write
//   ReadReg1  : read port 1 register number
//   ReadReg2  : read port 2 register number
//   ReadData1 : data selected by ReadReg1
//   ReadData2 : data selected by ReadReg2
//
// There is no handshake: every rising edge with RegWrite=1 (and Reset_n=1)
// commits, and both read ports are always valid.
// -----------------------------------------------------------------------------
module reg_file_32x32
    import reg_file_32x32_pkg::*;
#(
    parameter bit ZERO_REG0 = 1'b1,
    parameter bit BYPASS    = 1'b1
)(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2
);

    reg_sel_t  dec_onehot;
    reg_sel_t  wr_en;
    reg_data_t regs_q [REG_COUNT];
    logic [REG_COUNT-1:0][REG_WIDTH-1:0] regs;
    reg_data_t mux1, mux2;
    logic      byp1, byp2;
    logic      wr_target_zero;

    // ------------------------------------------------------------------
    // Write decoder: 5-to-32 one-hot
    // ------------------------------------------------------------------
    always_comb begin
        dec_onehot = '0;
        case (WriteReg)
            5'd0:  dec_onehot[0]  = 1'b1;
            5'd1:  dec_onehot[1]  = 1'b1;
            5'd2:  dec_onehot[2]  = 1'b1;
            5'd3:  dec_onehot[3]  = 1'b1;
            5'd4:  dec_onehot[4]  = 1'b1;
            5'd5:  dec_onehot[5]  = 1'b1;
            5'd6:  dec_onehot[6]  = 1'b1;
            5'd7:  dec_onehot[7]  = 1'b1;
            5'd8:  dec_onehot[8]  = 1'b1;
            5'd9:  dec_onehot[9]  = 1'b1;
            5'd10: dec_onehot[10] = 1'b1;
            5'd11: dec_onehot[11] = 1'b1;
            5'd12: dec_onehot[12] = 1'b1;
            5'd13: dec_onehot[13] = 1'b1;
            5'd14: dec_onehot[14] = 1'b1;
            5'd15: dec_onehot[15] = 1'b1;
            5'd16: dec_onehot[16] = 1'b1;
            5'd17: dec_onehot[17] = 1'b1;
            5'd18: dec_onehot[18] = 1'b1;
            5'd19: dec_onehot[19] = 1'b1;
            5'd20: dec_onehot[20] = 1'b1;
            5'd21: dec_onehot[21] = 1'b1;
            5'd22: dec_onehot[22] = 1'b1;
            5'd23: dec_onehot[23] = 1'b1;
            5'd24: dec_onehot[24] = 1'b1;
            5'd25: dec_onehot[25] = 1'b1;
            5'd26: dec_onehot[26] = 1'b1;
            5'd27: dec_onehot[27] = 1'b1;
            5'd28: dec_onehot[28] = 1'b1;
            5'd29: dec_onehot[29] = 1'b1;
            5'd30: dec_onehot[30] = 1'b1;
            5'd31: dec_onehot[31] = 1'b1;
            default: dec_onehot = '0;
        endcase
    end

    // Qualify with RegWrite; R0's enable is forced low when it is hardwired
    // so its storage simply stays at its reset value.
    always_comb begin
        wr_en = dec_onehot & {REG_COUNT{RegWrite}};
        if (ZERO_REG0) begin
            wr_en[0] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    for (genvar i = 0; i < REG_COUNT; i++) begin : g_regs
        reg32 u_reg (
            .clk   (Clk),
            .rst_n (Reset_n),
            .en    (wr_en[i]),
            .d     (WriteData),
            .q     (regs_q[i])
        );
    end

    always_comb begin
        regs = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] = regs_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Read multiplexer, one instance per port
    // ------------------------------------------------------------------
    function automatic reg_data_t read_mux(
        input reg_addr_t                        sel,
        input logic [REG_COUNT-1:0][REG_WIDTH-1:0] r
    );
        reg_data_t v;
        case (sel)
            5'd0:  v = r[0];
            5'd1:  v = r[1];
            5'd2:  v = r[2];
            5'd3:  v = r[3];
            5'd4:  v = r[4];
            5'd5:  v = r[5];
            5'd6:  v = r[6];
            5'd7:  v = r[7];
            5'd8:  v = r[8];
            5'd9:  v = r[9];
            5'd10: v = r[10];
            5'd11: v = r[11];
            5'd12: v = r[12];
            5'd13: v = r[13];
            5'd14: v = r[14];
            5'd15: v = r[15];
            5'd16: v = r[16];
            5'd17: v = r[17];
            5'd18: v = r[18];
            5'd19: v = r[19];
            5'd20: v = r[20];
            5'd21: v = r[21];
            5'd22: v = r[22];
            5'd23: v = r[23];
            5'd24: v = r[24];
            5'd25: v = r[25];
            5'd26: v = r[26];
            5'd27: v = r[27];
            5'd28: v = r[28];
            5'd29: v = r[29];
            5'd30: v = r[30];
            5'd31: v = r[31];
            default: v = '0;
        endcase
        return v;
    endfunction

    assign mux1 = read_mux(ReadReg1, regs);
    assign mux2 = read_mux(ReadReg2, regs);

    // ------------------------------------------------------------------
    // Write-first bypass. Suppressed in reset (writes are ignored then) and
    // when the target is the hardwired zero register (the write is dropped).
    // ------------------------------------------------------------------
    assign wr_target_zero = is_zero_reg(ZERO_REG0, WriteReg);
    assign byp1 = BYPASS && Reset_n && RegWrite && !wr_target_zero && (ReadReg1 == WriteReg);
    assign byp2 = BYPASS && Reset_n && RegWrite && !wr_target_zero && (ReadReg2 == WriteReg);

    // Final output selection. Reset forces 0 directly so the outputs do not
    // depend on the clear having propagated through storage.
    always_comb begin
        ReadData1 = mux1;
        if (!Reset_n || is_zero_reg(ZERO_REG0, ReadReg1)) begin
            ReadData1 = '0;
        end else if (byp1) begin
            ReadData1 = WriteData;
        end
    end

    always_comb begin
        ReadData2 = mux2;
        if (!Reset_n || is_zero_reg(ZERO_REG0, ReadReg2)) begin
            ReadData2 = '0;
        end else if (byp2) begin
            ReadData2 = WriteData;
        end
    end

endmodule : reg_file_32x32
